// File: rtl/final_pkg.sv
// final_pkg: shared state encoding, widths and default sizing for the final_sched job scheduler.
package final_pkg;
    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_I, WAIT, RECOVER} state_t;
    localparam int BEAT_W      = 128;
    localparam int OUT_W       = 13;
    localparam int DEF_N_W     = 4;
    localparam int DEF_N_I     = 16;
    localparam int DEF_N_OUT   = 4;
    localparam int DEF_TIMEOUT = 1024;
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        m = b > m ? b : m;
        m = c > m ? c : m;
        m = d > m ? d : m;
        return $clog2(m + 1);
    endfunction
endpackage

// File: rtl/final_rr_arb.sv
// final_rr_arb: 2-way round-robin arbiter; the pointer moves past the winner when a grant is taken.
module final_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] pick
);
    logic ptr;
    always_comb pick = ptr ? (req[1] ? 2'b10 : {1'b0, req[0]}) : (req[0] ? 2'b01 : {req[1], 1'b0});
    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= 1'b0;
        else if (advance) ptr <= pick[0];
endmodule

// File: rtl/final_sched.sv
// final_sched: arbitrates two requesters, streams W/I beats into Final and returns tagged results.
// Optional WAIT watchdog enabled by defining FINAL_SCHED_TIMEOUT_EN.
module final_sched
    import final_pkg::*;
#(
    parameter int N_W     = DEF_N_W,
    parameter int N_I     = DEF_N_I,
    parameter int N_OUT   = DEF_N_OUT,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [BEAT_W-1:0] src_data,
    output logic              dp_rst_n,
    output logic              dp_weight_valid,
    output logic [BEAT_W-1:0] dp_W,
    output logic              dp_in_valid,
    output logic [BEAT_W-1:0] dp_I,
    input  logic              dp_out_valid,
    input  logic [OUT_W-1:0]  dp_OUT,
    output logic              res_valid,
    output logic [OUT_W-1:0]  res_data,
    output logic              res_id,
    output logic              res_last,
    output logic              err
);
    localparam int CW = cnt_width(N_W, N_I, N_OUT, TIMEOUT);
    localparam logic [CW-1:0] W_LAST = CW'(N_W - 1);
    localparam logic [CW-1:0] I_LAST = CW'(N_I - 1);
    localparam logic [CW-1:0] O_LAST = CW'(N_OUT - 1);
    state_t        state;
    logic [CW-1:0] cnt, ocnt;
    logic [1:0]    pick;
    logic          take, brk, tmo, abort, advance;

    final_rr_arb u_arb (.clk(clk), .rst(rst), .req(req), .advance(advance), .pick(pick));

    // once the first W beat is in, every cycle of the stream must carry a beat
    always_comb begin
        take    = src_ready && src_valid;
        brk     = src_ready && !src_valid && (state == LOAD_I || cnt != '0);
`ifdef FINAL_SCHED_TIMEOUT_EN
        tmo     = state == WAIT && !dp_out_valid && cnt == CW'(TIMEOUT - 1);
`else
        tmo     = 1'b0;
`endif
        abort   = brk || tmo;
        advance = state == IDLE && req != 2'b00;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state           <= IDLE;
            gnt             <= '0;
            src_ready       <= 1'b0;
            dp_rst_n        <= 1'b0;
            dp_weight_valid <= 1'b0;
            dp_W            <= '0;
            dp_in_valid     <= 1'b0;
            dp_I            <= '0;
            res_valid       <= 1'b0;
            res_data        <= '0;
            res_id          <= 1'b0;
            res_last        <= 1'b0;
            err             <= 1'b0;
            cnt             <= '0;
            ocnt            <= '0;
        end else begin
            dp_weight_valid <= 1'b0;
            dp_in_valid     <= 1'b0;
            res_valid       <= 1'b0;
            res_last        <= 1'b0;
            err             <= 1'b0;
            if (abort) begin
                state     <= RECOVER;
                err       <= 1'b1;
                gnt       <= '0;
                src_ready <= 1'b0;
                dp_rst_n  <= 1'b0;
                cnt       <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        dp_rst_n <= 1'b1;
                        if (advance) begin
                            gnt       <= pick;
                            src_ready <= 1'b1;
                            cnt       <= '0;
                            state     <= LOAD_W;
                        end
                    end
                    LOAD_W: if (take) begin
                        dp_W            <= src_data;
                        dp_weight_valid <= 1'b1;
                        cnt             <= cnt == W_LAST ? '0 : cnt + 1'b1;
                        if (cnt == W_LAST) state <= LOAD_I;
                    end
                    LOAD_I: if (take) begin
                        dp_I        <= src_data;
                        dp_in_valid <= 1'b1;
                        cnt         <= cnt + 1'b1;
                        if (cnt == I_LAST) begin
                            src_ready <= 1'b0;
                            cnt       <= '0;
                            ocnt      <= '0;
                            state     <= WAIT;
                        end
                    end
                    WAIT: begin
`ifdef FINAL_SCHED_TIMEOUT_EN
                        cnt <= dp_out_valid ? '0 : cnt + 1'b1;
`endif
                        if (dp_out_valid) begin
                            res_valid <= 1'b1;
                            res_data  <= dp_OUT;
                            res_id    <= gnt[1];
                            ocnt      <= ocnt + 1'b1;
                            if (ocnt == O_LAST) begin
                                res_last <= 1'b1;
                                gnt      <= '0;
                                state    <= IDLE;
                            end
                        end
                    end
                    RECOVER: begin
                        cnt <= cnt + 1'b1;
                        if (cnt != '0) begin
                            dp_rst_n <= 1'b1;
                            cnt      <= '0;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
endmodule

// File: doc/final_sched.md
# final_sched

Job scheduler and stream sequencer in front of the `Final` serial MAC datapath. Two requesters share one `Final` instance. The block arbitrates round-robin and grants one job at a time. For the granted job it streams weight beats, then input beats, into `Final`, then forwards the 13-bit results back tagged with the requester id. On a broken stream or a hung datapath it resets `Final` and recovers.

## Interface
- `N_W`, 4: weight beats per job (128-bit each)
- `N_I`, 16: input beats per job
- `N_OUT`, 4: results expected from `Final` per job
- `TIMEOUT`, 1024: WAIT-state watchdog limit in cycles
- `clk` in 1: sole clock, rising edge
- `rst` in 1: one clock; reset is asynchronous and active-high
- `req` in 2: per-requester job request, level
- `gnt` out 2: one-hot grant, held for the whole job
- `src_valid` in 1: granted requester's beat valid
- `src_ready` out 1: block accepts a beat
- `src_data` in 128: beat payload (W, then I)
- `dp_rst_n` out 1: active-low reset to `Final`
- `dp_weight_valid` out 1, `dp_W` out 128: to `Final`
- `dp_in_valid` out 1, `dp_I` out 128: to `Final`
- `dp_out_valid` in 1, `dp_OUT` in 13: from `Final`
- `res_valid` out 1, `res_data` out 13, `res_id` out 1, `res_last` out 1: result return, no backpressure
- `err` out 1: one-cycle abort pulse

## Operation
- States: IDLE, LOAD_W, LOAD_I, WAIT, RECOVER.
- IDLE: if `req`≠0, the arbiter picks a requester. Pointer is 0 after reset and moves to the other requester after each job (completed or aborted). Sets `gnt` and goes to LOAD_W.
- LOAD_W: `src_ready`=1. Each accepted beat is copied to `dp_W` with `dp_weight_valid`=1. After `N_W` beats go to LOAD_I.
- LOAD_I: same flow on `dp_I`/`dp_in_valid`. After `N_I` beats `src_ready` drops and the state moves to WAIT.
- Stream rule: `src_valid` may stay low before the first W beat. After that, all `N_W`+`N_I` beats must be contiguous. A low `src_valid` mid-stream is a break and goes to RECOVER.
- WAIT: each `dp_out_valid` forwards `dp_OUT` to `res_data` with `res_valid`=1 and `res_id`=granted index. `res_last` is set on result `N_OUT`, then go to IDLE and clear `gnt`.
- `dp_out_valid` outside WAIT is ignored (no `res_valid`).
- RECOVER: `err`=1 for one cycle, `gnt` cleared, `dp_rst_n`=0 for 2 cycles, then IDLE.
- `req` dropping during a job does not abort it.
- Counters are sized clog2(max(`N_W`,`N_I`,`N_OUT`,`TIMEOUT`)+1).

## Timing
- Reset values: all outputs 0, including `dp_rst_n`=0, so `Final` is held in reset. `dp_rst_n` rises 1 cycle after `rst` deasserts.
- `rst` asserted mid-job clears every output immediately (asynchronous). After release the state is IDLE.
- `gnt` asserts 1 cycle after `req` is sampled in IDLE. `src_ready` rises in the same cycle.
- Datapath latency: `dp_*` valid/data follow an accepted beat by 1 cycle.
- Result latency: `res_*` follows `dp_out_valid` by 1 cycle.
- The last I beat and the first W beat of the next job are at least 2 cycles apart (WAIT, IDLE).
- Back-to-back grants: `gnt` deasserts for exactly one IDLE cycle between jobs.

## Configuration
- `FINAL_SCHED_TIMEOUT_EN` defined: WAIT counts cycles since entry and since each result. Reaching `TIMEOUT` goes to RECOVER.
- `FINAL_SCHED_TIMEOUT_EN` not defined: WAIT waits indefinitely. `err` comes only from a stream break. `TIMEOUT` is unused.

## Structure
- Package `final_pkg`: state enum, `BEAT_W`=128, `OUT_W`=13, default `N_W`/`N_I`/`N_OUT`/`TIMEOUT` constants.
- Sub-module `final_rr_arb`: 2-way round-robin arbiter. Inputs `req` and `advance`; outputs one-hot `pick`.
- The FSM, counters and datapath registers live in `final_sched`.

## Test plan
- `req`=01, 4 W beats then 16 I beats contiguous, model returns 4 results → `gnt`=01 one cycle later, `dp_weight_valid` high 4 cycles, `dp_in_valid` high 16 cycles, 4×`res_valid` with `res_id`=0, `res_last` on the 4th, `gnt`=00 next cycle.
- `req`=11 held after reset for 4 jobs → grant order 0,1,0,1, with a one-cycle `gnt`=00 gap between jobs.
- `src_valid` low after W beat 2 → `err` pulse, `dp_rst_n` low 2 cycles, no `dp_in_valid`, IDLE, pointer advanced.
- Macro defined, `TIMEOUT`=1024, no `dp_out_valid` after last I beat → `err` in the cycle after 1024 idle cycles, `dp_rst_n` pulse. Macro undefined → still in WAIT at 5000 cycles.
- `rst` asserted mid LOAD_I → all outputs 0 in the same cycle. After release, first job behaves as in the first scenario.
- `dp_out_valid`=1 with `dp_OUT`=13'h1A5 while IDLE → no `res_valid`.
